// File: rtl/ps2_receiver.sv
// PS/2 host receiver: synchronizes ps2_clk/ps2_data, deframes 11-bit frames and queues scan codes.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd-parity bit is wrong.
module ps2_receiver #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    ps2_clk_sync;
  logic [1:0]    ps2_data_sync;
  logic          fall;
  logic          bit_in;
  logic [3:0]    cnt;
  logic [9:0]    buffer;
  logic [TW-1:0] tcnt;
  logic          frame_done;
  logic          frame_ok;
  logic          timeout;
  logic [7:0]    fifo [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  function automatic logic frame_valid(input logic [9:0] b, input logic stop);
    logic ok;
    ok = ~b[0] & stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok & (^b[9:1]);
`endif
    return ok;
  endfunction

  // Synchronizer stage: clock sync resets high so reset release never looks like a falling edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync  <= 3'b111;
      ps2_data_sync <= 2'b11;
    end else begin
      ps2_clk_sync  <= {ps2_clk_sync[1:0], ps2_clk};
      ps2_data_sync <= {ps2_data_sync[0], ps2_data};
    end
  end

  assign fall       = ps2_clk_sync[2] & ~ps2_clk_sync[1];
  assign bit_in     = ps2_data_sync[1];
  assign frame_done = fall && (cnt == 4'd10);
  assign frame_ok   = frame_valid(buffer, bit_in);
  assign timeout    = !fall && (cnt != 4'd0) && (tcnt == TW'(TIMEOUT_CYCLES));

  // Deframer stage: bits shift in from the top so the start bit lands in buffer[0] after ten edges
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt       <= '0;
      buffer    <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (frame_done && !frame_ok) || timeout;
      if (fall) begin
        tcnt <= '0;
        if (cnt == 4'd10) begin
          cnt <= '0;
        end else begin
          buffer <= {bit_in, buffer[9:1]};
          cnt    <= cnt + 4'd1;
        end
      end else if (timeout) begin
        cnt  <= '0;
        tcnt <= '0;
      end else if (cnt != 4'd0) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = frame_done && frame_ok;
  assign pop   = !nextdata_n && !empty;

  // FIFO stage: a pop in the same cycle frees the slot a push into a full FIFO needs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (pop) rptr <= rptr + 1'b1;
      if (push) begin
        if (!full || pop) begin
          fifo[wptr[AW-1:0]] <= buffer[8:1];
          wptr               <= wptr + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign ready = !empty;
  assign data  = fifo[rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed and random PS/2 frames with pops, checked every cycle
// against a queue model of the receive FIFO plus a few hand-computed pop sequences.
module tb_ps2_receiver;
  localparam int DEPTH = 8;
  localparam int TMO   = 2000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_receiver #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Model state (written only by the model process)
  longint     cyc = 0;
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;
  longint     mask_lo = -10;
  longint     mask_hi = -10;
  int         n_done = 0;

  // Frame events posted by the stimulus (written only by the main process)
  longint     ev_due [256];
  logic [7:0] ev_code[256];
  int         ev_kind[256];
  int         n_sent = 0;

  // Literal checks queued by the main process, evaluated by the compare process
  string       lq_name[128];
  logic [31:0] lq_act [128];
  logic [31:0] lq_exp [128];
  int          lq_n = 0;
  int          lq_done = 0;

  int checks = 0;
  int failures = 0;
  int win_pulses = 0;
  int dut_ferr_cnt = 0;

  logic [7:0] popped[16];
  int         pop_n = 0;
  bit         rnd_pop = 1'b0;

  // Kind 0: valid code, 1: bad frame, 2: last edge of an abandoned partial frame
  always @(posedge clk) begin
    cyc++;
    if (!clrn) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b0;
      if (!nextdata_n && mq.size() != 0) void'(mq.pop_front());
      while (n_done < n_sent && ev_due[n_done] <= cyc) begin
        case (ev_kind[n_done])
          0: if (mq.size() < DEPTH) mq.push_back(ev_code[n_done]); else m_ovf = 1'b1;
          1: m_ferr = 1'b1;
          default: begin
            mask_lo = cyc + TMO - 2;
            mask_hi = cyc + TMO + 3;
          end
        endcase
        n_done++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (frame_err) dut_ferr_cnt++;
    checks++;
    if (ready !== (mq.size() != 0)) begin
      failures++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      checks++;
      if (data !== mq[0]) begin
        failures++;
        $display("FAIL data cyc=%0d got=%h exp=%h", cyc, data, mq[0]);
      end
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
    end
    if (cyc >= mask_lo && cyc <= mask_hi) begin
      if (frame_err) win_pulses++;
    end else begin
      checks++;
      if (frame_err !== m_ferr) begin
        failures++;
        $display("FAIL frame_err cyc=%0d got=%b exp=%b", cyc, frame_err, m_ferr);
      end
    end
    if (cyc == mask_hi + 1) begin
      checks++;
      if (win_pulses != 1) begin
        failures++;
        $display("FAIL timeout_pulse cyc=%0d got=%0d cycles high exp=1", cyc, win_pulses);
      end
      win_pulses = 0;
    end
    while (lq_done < lq_n) begin
      checks++;
      if (lq_act[lq_done] !== lq_exp[lq_done]) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", lq_name[lq_done], lq_act[lq_done], lq_exp[lq_done]);
      end
      lq_done++;
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lq_name[lq_n] = nm;
    lq_act[lq_n]  = act;
    lq_exp[lq_n]  = exp;
    lq_n++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_pop) nextdata_n = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Frame bit i goes on the wire i-th: start, code LSB first, odd parity, stop
  function automatic logic [10:0] mk_frame(input logic [7:0] code, input int corrupt);
    logic [10:0] f;
    f = {1'b1, ~^code, code, 1'b0};
    case (corrupt)
      1: f[0]  = 1'b1;
      2: f[10] = 1'b0;
      3: f[9]  = ~f[9];
      default: ;
    endcase
    return f;
  endfunction

  task automatic send_raw(input logic [10:0] f, input int nbits, input int tail_kind,
                          input bit pop_on_stop);
    bit ok;
    int kind;
    ok   = (f[0] == 1'b0) && (f[10] == 1'b1) && (!PAR_EN || (^f[9:1]) == 1'b1);
    kind = (nbits == 11) ? (ok ? 0 : 1) : tail_kind;
    tick(1);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(3);
      ps2_clk = 1'b0;
      if (i == nbits - 1 && kind >= 0) begin
        ev_due[n_sent]  = cyc + 3;
        ev_code[n_sent] = f[8:1];
        ev_kind[n_sent] = kind;
        n_sent++;
      end
      if (i == nbits - 1 && pop_on_stop) begin
        tick(2);
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
      end else begin
        tick(3);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_code(input logic [7:0] code, input int corrupt);
    send_raw(mk_frame(code, corrupt), 11, -1, 1'b0);
  endtask

  task automatic pop_all();
    pop_n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!ready) break;
      popped[pop_n] = data;
      pop_n++;
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
    end
    lit("drained_ready", 32'(ready), 32'd0);
  endtask

  initial begin
    int base;
    clrn = 1'b0;
    tick(5);
    lit("rst_ready", 32'(ready), 32'd0);
    lit("rst_data", 32'(data), 32'd0);
    lit("rst_overflow", 32'(overflow), 32'd0);
    lit("rst_frame_err", 32'(frame_err), 32'd0);
    clrn = 1'b1;
    tick(5);

    send_code(8'h1C, 0);
    lit("single_ready", 32'(ready), 32'd1);
    lit("single_data", 32'(data), 32'h1C);
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    lit("single_after_pop", 32'(ready), 32'd0);

    base = dut_ferr_cnt;
    send_code(8'hF0, 0);
    send_code(8'h1C, 0);
    send_code(8'hE0, 0);
    pop_all();
    lit("b2b_count", 32'(pop_n), 32'd3);
    lit("b2b_0", 32'(popped[0]), 32'hF0);
    lit("b2b_1", 32'(popped[1]), 32'h1C);
    lit("b2b_2", 32'(popped[2]), 32'hE0);
    lit("b2b_frame_err", 32'(dut_ferr_cnt - base), 32'd0);

    for (int i = 0; i < 8; i++) send_code(8'(8'h10 + i), 0);
    send_raw(mk_frame(8'h18, 0), 11, -1, 1'b1);
    lit("fullpop_overflow", 32'(overflow), 32'd0);
    pop_all();
    lit("fullpop_count", 32'(pop_n), 32'd8);
    lit("fullpop_first", 32'(popped[0]), 32'h11);
    lit("fullpop_last", 32'(popped[7]), 32'h18);

    for (int i = 1; i <= 9; i++) send_code(8'(i), 0);
    lit("ovf_flag", 32'(overflow), 32'd1);
    pop_all();
    lit("ovf_count", 32'(pop_n), 32'd8);
    lit("ovf_first", 32'(popped[0]), 32'h01);
    lit("ovf_last", 32'(popped[7]), 32'h08);
    lit("ovf_sticky", 32'(overflow), 32'd1);

    base = dut_ferr_cnt;
    send_code(8'h1C, 3);
    lit("parity_ready", 32'(ready), 32'(!PAR_EN));
    lit("parity_frame_err", 32'(dut_ferr_cnt - base), 32'(PAR_EN));
    pop_all();
    lit("parity_popped", 32'(pop_n), 32'(!PAR_EN));

    base = dut_ferr_cnt;
    send_raw(mk_frame(8'hAA, 0), 5, 2, 1'b0);
    tick(TMO + 20);
    lit("timeout_frame_err", 32'(dut_ferr_cnt - base), 32'd1);
    send_code(8'h29, 0);
    lit("post_timeout_ready", 32'(ready), 32'd1);
    lit("post_timeout_data", 32'(data), 32'h29);
    pop_all();

    rnd_pop = 1'b1;
    for (int i = 0; i < 40; i++) send_code(8'($urandom), int'($urandom_range(0, 7)));
    rnd_pop = 1'b0;
    nextdata_n = 1'b1;
    pop_all();

    send_raw(mk_frame(8'h55, 0), 6, -1, 1'b0);
    clrn = 1'b0;
    tick(3);
    lit("midrst_ready", 32'(ready), 32'd0);
    lit("midrst_overflow", 32'(overflow), 32'd0);
    lit("midrst_frame_err", 32'(frame_err), 32'd0);
    clrn = 1'b1;
    tick(10);
    send_code(8'h3A, 0);
    lit("midrst_next_ready", 32'(ready), 32'd1);
    lit("midrst_next_data", 32'(data), 32'h3A);
    pop_all();

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
